irq_injector: RTL and testbench

Parametrised, synthesizable interrupt stimulus generator for the pipelined MIPS CPU benches. It watches the CPU's committed-PC `addr` output. When `addr` matches a per-channel trigger address, it drives a timed pulse on one bit of the `HWInt` interrupt vector. It supersedes single-shot, single-line bench code with N independent channels, runtime programming, re-arm and level/ack modes.

---
 rtl/irq_injector_pkg.sv | 27 ++
 rtl/irq_inj_channel.sv | 163 ++++++++++++++++
 rtl/irq_injector.sv | 76 +++++++
 tb/tb_irq_injector.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_injector_pkg.sv
// -----------------------------------------------------------------------------
// irq_injector_pkg
// Shared definitions for the interrupt stimulus generator:
//   - per-channel FSM state codes (legacy-compatible localparam constants)
//   - channel mode encodings written through the configuration port
// Optional feature macro used by the design: IRQ_INJECTOR_DELAY_EN
// -----------------------------------------------------------------------------
package irq_injector_pkg;

    typedef logic [2:0] ch_state_t;

    // Channel FSM states. ST_DELAY is only reachable when the delay
    // feature is compiled in.
    localparam ch_state_t ST_IDLE       = 3'd0;
    localparam ch_state_t ST_ARMED      = 3'd1;
    localparam ch_state_t ST_DELAY      = 3'd2;
    localparam ch_state_t ST_ACTIVE     = 3'd3;
    localparam ch_state_t ST_SPENT      = 3'd4;
    localparam ch_state_t ST_WAIT_LEAVE = 3'd5;

    // Channel modes.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_REARM   = 2'd1;
    localparam logic [1:0] MODE_LEVEL   = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

endpackage

// File: rtl/irq_inj_channel.sv
// -----------------------------------------------------------------------------
// irq_inj_channel
// One interrupt channel: trigger/length/mode registers, FSM and pulse counter.
// A PC match while armed starts a pulse whose rising edge is one clock after
// the sampling edge. Optional macro IRQ_INJECTOR_DELAY_EN inserts a
// programmable delay between the match and the pulse.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_addr        - committed PC from the CPU
//   i_en          - global enable for accepting new matches
//   i_cfg_we      - configuration write already decoded for this channel
//   i_cfg_addr    - trigger address to load
//   i_cfg_len     - pulse length minus one
//   i_cfg_mode    - channel mode
//   i_cfg_dly     - match-to-pulse delay (only with IRQ_INJECTOR_DELAY_EN)
//   i_ack         - acknowledge, used only in level mode
//   o_irq         - registered interrupt line
//   o_fired       - sticky flag, set when o_irq first rises
// -----------------------------------------------------------------------------
module irq_inj_channel
    import irq_injector_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    input  logic              i_cfg_we,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic [1:0]        i_cfg_mode,
`ifdef IRQ_INJECTOR_DELAY_EN
    input  logic [LEN_W-1:0]  i_cfg_dly,
`endif
    input  logic              i_ack,
    output logic              o_irq,
    output logic              o_fired
);

    logic [ADDR_W-1:0] r_trig;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_mode;
    ch_state_t         r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_irq;
    logic              r_fired;
`ifdef IRQ_INJECTOR_DELAY_EN
    logic [LEN_W-1:0]  r_dly;
`endif

    ch_state_t         w_state_nx;
    logic [LEN_W-1:0]  w_cnt_nx;
    logic              w_irq_nx;
    logic              w_match;

    assign w_match = i_en && (i_addr == r_trig);

    // Next-state, counter and next-irq computation for the channel FSM.
    // The irq register follows the ACTIVE state one edge late, except that
    // an acknowledge drops it on the acknowledge edge itself.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_irq_nx   = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_match) begin
`ifdef IRQ_INJECTOR_DELAY_EN
                    if (r_dly == {LEN_W{1'b0}}) begin
                        w_state_nx = ST_ACTIVE;
                        w_cnt_nx   = r_len;
                    end else begin
                        // Counter holds the remaining delay while in DELAY.
                        w_state_nx = ST_DELAY;
                        w_cnt_nx   = r_dly;
                    end
`else
                    w_state_nx = ST_ACTIVE;
                    w_cnt_nx   = r_len;
`endif
                end else begin
                    w_state_nx = ST_ARMED;
                end
            end
`ifdef IRQ_INJECTOR_DELAY_EN
            ST_DELAY: begin
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nx = ST_ACTIVE;
                    w_cnt_nx   = r_len;
                end else begin
                    w_cnt_nx   = r_cnt - LEN_W'(1);
                end
            end
`endif
            ST_ACTIVE: begin
                if (r_mode == MODE_LEVEL) begin
                    if (i_ack) begin
                        w_state_nx = ST_WAIT_LEAVE;
                        w_irq_nx   = 1'b0;
                    end else begin
                        w_irq_nx   = 1'b1;
                    end
                end else begin
                    w_irq_nx = 1'b1;
                    if (r_cnt == {LEN_W{1'b0}}) begin
                        w_state_nx = (r_mode == MODE_REARM) ? ST_WAIT_LEAVE : ST_SPENT;
                    end else begin
                        w_cnt_nx   = r_cnt - LEN_W'(1);
                    end
                end
            end
            ST_WAIT_LEAVE: begin
                // Re-arm only after the PC moves off the trigger so a
                // stalled PC cannot retrigger.
                if (i_addr != r_trig) begin
                    w_state_nx = ST_ARMED;
                end else begin
                    w_state_nx = ST_WAIT_LEAVE;
                end
            end
            default: begin
                w_state_nx = r_state;
            end
        endcase
    end

    // Channel registers; a configuration write overrides every other event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig  <= {ADDR_W{1'b0}};
            r_len   <= {LEN_W{1'b0}};
            r_mode  <= MODE_OFF;
            r_state <= ST_IDLE;
            r_cnt   <= {LEN_W{1'b0}};
            r_irq   <= 1'b0;
            r_fired <= 1'b0;
`ifdef IRQ_INJECTOR_DELAY_EN
            r_dly   <= {LEN_W{1'b0}};
`endif
        end else if (i_cfg_we) begin
            r_trig  <= i_cfg_addr;
            r_len   <= i_cfg_len;
            r_mode  <= i_cfg_mode;
            r_state <= (i_cfg_mode == MODE_OFF) ? ST_IDLE : ST_ARMED;
            r_cnt   <= {LEN_W{1'b0}};
            r_irq   <= 1'b0;
`ifdef IRQ_INJECTOR_DELAY_EN
            r_dly   <= i_cfg_dly;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_irq   <= w_irq_nx;
            r_fired <= r_fired | w_irq_nx;
        end
    end

    assign o_irq   = r_irq;
    assign o_fired = r_fired;

endmodule

// File: rtl/irq_injector.sv
// -----------------------------------------------------------------------------
// irq_injector
// Interrupt stimulus generator for the pipelined MIPS CPU benches. N_CH
// independent channels watch the committed PC and pulse one bit each of the
// HWInt vector when the PC hits their programmed trigger address.
// Optional macro: IRQ_INJECTOR_DELAY_EN adds the cfg_dly port and a
// per-channel match-to-pulse delay.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   addr        - committed PC
//   en          - global enable for new matches
//   cfg_we      - configuration write strobe
//   cfg_ch      - channel to configure (values >= N_CH ignored)
//   cfg_addr    - trigger address
//   cfg_len     - pulse length minus one
//   cfg_mode    - 0 one-shot, 1 re-arm, 2 level-until-ack, 3 disabled
//   cfg_dly     - delay in cycles (only with IRQ_INJECTOR_DELAY_EN)
//   irq_ack     - per-channel acknowledge for level mode
//   irq         - registered interrupt lines
//   fired       - sticky per-channel "has fired" flags
// -----------------------------------------------------------------------------
module irq_injector
    import irq_injector_pkg::*;
#(
    parameter int N_CH   = 6,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    en,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [1:0]              cfg_mode,
`ifdef IRQ_INJECTOR_DELAY_EN
    input  logic [LEN_W-1:0]        cfg_dly,
`endif
    input  logic [N_CH-1:0]         irq_ack,
    output logic [N_CH-1:0]         irq,
    output logic [N_CH-1:0]         fired
);

    localparam int CH_W = $clog2(N_CH);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic w_sel;

        // Only channel indices below N_CH exist, so out-of-range cfg_ch
        // values select nothing.
        assign w_sel = cfg_we && (cfg_ch == CH_W'(g));

        irq_inj_channel #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_addr     (addr),
            .i_en       (en),
            .i_cfg_we   (w_sel),
            .i_cfg_addr (cfg_addr),
            .i_cfg_len  (cfg_len),
            .i_cfg_mode (cfg_mode),
`ifdef IRQ_INJECTOR_DELAY_EN
            .i_cfg_dly  (cfg_dly),
`endif
            .i_ack      (irq_ack[g]),
            .o_irq      (irq[g]),
            .o_fired    (fired[g])
        );
    end

endmodule

// File: tb/tb_irq_injector.sv
module tb_irq_injector;

    localparam int N_CH   = 6;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [ADDR_W-1:0] cfg_addr;
    logic [LEN_W-1:0]  cfg_len;
    logic [1:0]        cfg_mode;
`ifdef IRQ_INJECTOR_DELAY_EN
    logic [LEN_W-1:0]  cfg_dly;
`endif
    logic [N_CH-1:0]   irq_ack;
    logic [N_CH-1:0]   irq;
    logic [N_CH-1:0]   fired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_injector #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_addr (cfg_addr),
        .cfg_len  (cfg_len),
        .cfg_mode (cfg_mode),
`ifdef IRQ_INJECTOR_DELAY_EN
        .cfg_dly  (cfg_dly),
`endif
        .irq_ack  (irq_ack),
        .irq      (irq),
        .fired    (fired)
    );

    typedef struct {
        logic        we;
        logic [2:0]  ch;
        logic [31:0] caddr;
        logic [3:0]  len;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [5:0]  exp_irq;
        logic [5:0]  exp_fired;
    } vec_t;

    vec_t vecs[$];

    // Reference model state (pulse-countdown view of each channel)
    logic [31:0] m_trig  [N_CH];
    logic [3:0]  m_len   [N_CH];
    logic [1:0]  m_mode  [N_CH];
    int          m_dly   [N_CH];
    bit          m_armed [N_CH];
    bit          m_wait  [N_CH];
    int          m_start [N_CH];
    bit          m_act   [N_CH];
    int          m_left  [N_CH];
    logic [5:0]  m_irq;
    logic [5:0]  m_fired;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic we, input logic [2:0] ch, input logic [31:0] ca,
                           input logic [3:0] ln, input logic [1:0] md, input logic [31:0] a,
                           input logic [5:0] ei, input logic [5:0] ef);
        vec_t v;
        v.we = we; v.ch = ch; v.caddr = ca; v.len = ln; v.mode = md;
        v.addr = a; v.exp_irq = ei; v.exp_fired = ef;
        vecs.push_back(v);
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [31:0] ca, input logic [3:0] ln,
                       input logic [1:0] md);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = ca; cfg_len = ln; cfg_mode = md;
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_trig[c] = 32'h0; m_len[c] = 4'd0; m_mode[c] = 2'd3; m_dly[c] = 0;
            m_armed[c] = 1'b0; m_wait[c] = 1'b0; m_start[c] = 0; m_act[c] = 1'b0; m_left[c] = 0;
        end
        m_irq = 6'd0;
        m_fired = 6'd0;
    endtask

    // Predicts irq after the coming edge from the inputs currently driven.
    task automatic model_step();
        for (int c = 0; c < N_CH; c++) begin
            bit q;
            q = 1'b0;
            if (cfg_we && int'(cfg_ch) == c) begin
                m_trig[c] = cfg_addr; m_len[c] = cfg_len; m_mode[c] = cfg_mode;
`ifdef IRQ_INJECTOR_DELAY_EN
                m_dly[c] = int'(cfg_dly);
`else
                m_dly[c] = 0;
`endif
                m_armed[c] = (cfg_mode != 2'd3);
                m_wait[c] = 1'b0; m_start[c] = 0; m_act[c] = 1'b0; m_left[c] = 0;
            end else begin
                if (m_start[c] > 0) begin
                    m_start[c]--;
                    if (m_start[c] == 0) begin
                        m_act[c] = 1'b1;
                        m_left[c] = int'(m_len[c]) + 1;
                    end
                end
                if (m_act[c]) begin
                    if (m_mode[c] == 2'd2) begin
                        if (irq_ack[c]) begin
                            m_act[c] = 1'b0; m_wait[c] = 1'b1;
                        end else begin
                            q = 1'b1;
                        end
                    end else begin
                        q = 1'b1;
                        m_left[c]--;
                        if (m_left[c] == 0) begin
                            m_act[c] = 1'b0;
                            m_wait[c] = (m_mode[c] == 2'd1);
                        end
                    end
                end else if (m_start[c] == 0) begin
                    if (m_wait[c]) begin
                        if (addr != m_trig[c]) begin
                            m_wait[c] = 1'b0; m_armed[c] = 1'b1;
                        end
                    end else if (m_armed[c] && en && addr == m_trig[c]) begin
                        m_armed[c] = 1'b0;
                        m_start[c] = m_dly[c] + 1;
                    end
                end
            end
            m_irq[c] = q;
            if (q) m_fired[c] = 1'b1;
        end
    endtask

    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};

    initial begin
        reset = 1'b1; addr = 32'h0; en = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0;
        cfg_addr = 32'h0; cfg_len = 4'd0; cfg_mode = 2'd3; irq_ack = 6'd0;
`ifdef IRQ_INJECTOR_DELAY_EN
        cfg_dly = 4'd0;
`endif
        tick(); tick();
        check("reset_irq", irq, 6'd0);
        check("reset_fired", fired, 6'd0);
        reset = 1'b0;
        tick();

        // ---- table-driven directed vectors ----
        // ch0 one-shot len 5 at 0x3010, hit during and after the pulse
        add_vec(1, 3'd0, 32'h3010, 4'd5, 2'd0, 32'h0,    6'b000000, 6'b000000);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h3010, 6'b000000, 6'b000000);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h3010, 6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000001, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h3010, 6'b000000, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b000001);
        // ch1 re-arm len 0 at 0x2000, held 4 cycles then leaves and returns
        add_vec(1, 3'd1, 32'h2000, 4'd0, 2'd1, 32'h0,    6'b000000, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000000, 6'b000001);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000010, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000010, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b000011);
        // out-of-range channel write must not touch any channel
        add_vec(1, 3'd6, 32'h2000, 4'd0, 2'd0, 32'h0,    6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h2000, 6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000010, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b000011);
        // ch0 len 2 and ch3 len 4 sharing 0x4198
        add_vec(1, 3'd0, 32'h4198, 4'd2, 2'd0, 32'h0,    6'b000000, 6'b000011);
        add_vec(1, 3'd3, 32'h4198, 4'd4, 2'd0, 32'h0,    6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h4198, 6'b000000, 6'b000011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b001001, 6'b001011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b001001, 6'b001011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b001001, 6'b001011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b001000, 6'b001011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b001000, 6'b001011);
        add_vec(0, 3'd0, 32'h0,    4'd0, 2'd0, 32'h0,    6'b000000, 6'b001011);

        foreach (vecs[i]) begin
            cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_addr = vecs[i].caddr;
            cfg_len = vecs[i].len; cfg_mode = vecs[i].mode; addr = vecs[i].addr;
            en = 1'b1; irq_ack = 6'd0;
            tick();
            check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
            check($sformatf("vec%0d_fired", i), fired, vecs[i].exp_fired);
        end
        cfg_we = 1'b0;

        // ---- ch2 level mode, ack after 10 high cycles with same-cycle rematch ----
        cfg(3'd2, 32'h5000, 4'd0, 2'd2); addr = 32'h0;
        tick(); cfg_we = 1'b0;
        check("lvl_cfg", irq, 6'd0);
        addr = 32'h5000;
        tick();
        check("lvl_match", irq, 6'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("lvl_high%0d", k), irq, 6'b000100);
        end
        irq_ack = 6'b000100;
        tick();
        check("lvl_ack", irq, 6'd0);
        irq_ack = 6'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lvl_stall%0d", k), irq, 6'd0);
        end
        addr = 32'h0;    tick(); check("lvl_leave", irq, 6'd0);
        addr = 32'h5000; tick(); check("lvl_rematch", irq, 6'd0);
        addr = 32'h0;    tick(); check("lvl_refire", irq, 6'b000100);
        cfg(3'd2, 32'h5000, 4'd0, 2'd2);
        tick(); cfg_we = 1'b0;
        check("lvl_cfg_abort", irq, 6'd0);
        tick();
        check("lvl_after_abort", irq, 6'd0);
        check("lvl_fired", fired, 6'b001111);

`ifdef IRQ_INJECTOR_DELAY_EN
        // ---- delay: pulse starts dly+1 edges after the match edge ----
        cfg(3'd5, 32'h7000, 4'd1, 2'd0); cfg_dly = 4'd3; addr = 32'h0;
        tick(); cfg_we = 1'b0;
        addr = 32'h7000; tick(); addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("dly_wait%0d", k), irq, 6'd0);
        end
        tick(); check("dly_high0", irq, 6'b100000);
        tick(); check("dly_high1", irq, 6'b100000);
        tick(); check("dly_end", irq, 6'd0);
        cfg(3'd5, 32'h7000, 4'd1, 2'd0);
        tick(); cfg_we = 1'b0;
        addr = 32'h7000; tick(); addr = 32'h0;
        tick(); tick();
        cfg(3'd5, 32'h7000, 4'd1, 2'd0);
        tick(); cfg_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("dly_abort%0d", k), irq, 6'd0);
        end
        cfg_dly = 4'd0;
`endif

        // ---- asynchronous reset in the middle of a pulse ----
        cfg(3'd4, 32'h6000, 4'd15, 2'd0); addr = 32'h0;
        tick(); cfg_we = 1'b0;
        addr = 32'h6000; tick(); addr = 32'h0;
        tick(); tick(); tick();
        check("rst_pre_pulse", irq & 6'b010000, 6'b010000);
        #2 reset = 1'b1;
        #1;
        check("rst_async_irq", irq, 6'd0);
        check("rst_async_fired", fired, 6'd0);
        tick();
        reset = 1'b0;
        addr = 32'h6000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_silent%0d", k), irq, 6'd0);
        end
        check("rst_silent_fired", fired, 6'd0);

        // ---- randomized run against the reference model ----
        reset = 1'b1;
        tick();
        model_reset();
        reset = 1'b0;
        addr = pool[0];
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cfg_we   = ($urandom_range(15) == 0);
            cfg_ch   = 3'($urandom_range(7));
            cfg_addr = pool[$urandom_range(3)];
            cfg_len  = 4'($urandom_range(3));
            cfg_mode = 2'($urandom_range(3));
`ifdef IRQ_INJECTOR_DELAY_EN
            cfg_dly  = 4'($urandom_range(3));
`endif
            if ($urandom_range(3) == 0) begin
                addr = ($urandom_range(2) == 0) ? 32'($urandom) : pool[$urandom_range(3)];
            end
            en      = ($urandom_range(9) != 0);
            irq_ack = 6'($urandom) & 6'($urandom) & 6'($urandom);
            model_step();
            tick();
            check($sformatf("rnd%0d_irq", cyc), irq, m_irq);
            check($sformatf("rnd%0d_fired", cyc), fired, m_fired);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
